// File: rtl/ecc_lockstep_chk.sv
// Lockstep SECDED checker for FIFO/RAM read paths: two identical decoders per word,
// cross-compared each cycle, with saturating event counters, sticky fault and fault injection.

module ecc_secded_dec #(
  parameter int DATA_WIDTH   = 172,
  parameter int PARITY_WIDTH = 9
) (
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [PARITY_WIDTH-1:0] parity_in,
  input  logic                    bypass,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [DATA_WIDTH-1:0]   mask,
  output logic                    sbit_err,
  output logic                    dbit_err
);
  localparam int R = PARITY_WIDTH - 1;

  // Data bit k occupies the k-th non-power-of-two codeword position (1-based).
  function automatic logic [DATA_WIDTH*R-1:0] build_pos_tbl();
    logic [DATA_WIDTH*R-1:0] tbl;
    int k;
    tbl = '0;
    k   = 0;
    for (int p = 1; p < (32'sd1 <<< R); p++) begin
      if (((p & (p - 32'sd1)) != 32'sd0) && (k < DATA_WIDTH)) begin
        tbl[k*R +: R] = R'(p);
        k++;
      end
    end
    return tbl;
  endfunction

  localparam logic [DATA_WIDTH*R-1:0] POS_TBL = build_pos_tbl();

  function automatic logic [R-1:0] calc_syndrome(input logic [DATA_WIDTH-1:0] d,
                                                 input logic [R-1:0]          chk);
    logic [R-1:0] syn;
    syn = chk;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (d[i]) syn = syn ^ POS_TBL[i*R +: R];
    end
    return syn;
  endfunction

  function automatic logic pow2_or_zero(input logic [R-1:0] v);
    return (v & (v - {{(R-1){1'b0}}, 1'b1})) == {R{1'b0}};
  endfunction

  logic [R-1:0]          syn_s;
  logic                  overall_s;
  logic [DATA_WIDTH-1:0] hit_s;

  // Syndrome decode: locate a single flipped data bit or classify the error
  always_comb begin
    syn_s     = calc_syndrome(data_in, parity_in[R-1:0]);
    overall_s = ^{data_in, parity_in};
    hit_s     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      hit_s[i] = (POS_TBL[i*R +: R] == syn_s);
    end
    mask     = '0;
    sbit_err = 1'b0;
    dbit_err = 1'b0;
    if (bypass) begin
      mask     = '0;
      sbit_err = 1'b0;
      dbit_err = 1'b0;
    end else if (overall_s) begin
      // odd parity: one flip, in data (hit), a check bit (power of two) or overall bit (zero)
      mask     = hit_s;
      sbit_err = (hit_s != '0) || pow2_or_zero(syn_s);
      dbit_err = ~sbit_err;
    end else begin
      mask     = '0;
      sbit_err = 1'b0;
      dbit_err = (syn_s != {R{1'b0}});
    end
    data_out = data_in ^ mask;
  end
endmodule

module ecc_lockstep_chk #(
  parameter int DATA_WIDTH   = 172,
  parameter int PARITY_WIDTH = 9,
  parameter int CNT_WIDTH    = 16,
  parameter int FAULT_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [PARITY_WIDTH-1:0] parity_in,
  input  logic                    bypass,
  input  logic                    detc_en,
  input  logic                    inj_req,
  input  logic                    cnt_clr,
  output logic                    valid_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic                    ecc_fault,
  output logic                    inj_busy,
  output logic                    fault_sticky,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic                    irq
);
  typedef enum logic [0:0] {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_e;

  localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(FAULT_THRESH);
  localparam logic                 IRQ_EN = (FAULT_THRESH != 32'sd0);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 ev);
    if (ev && (cnt != {CNT_WIDTH{1'b1}})) return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    else return cnt;
  endfunction

  inj_state_e                inj_state_r;
  logic                      s1_valid_r;
  logic [DATA_WIDTH-1:0]     s1_data_r;
  logic [PARITY_WIDTH-1:0]   s1_parity_r;
  logic                      s1_bypass_r;
  logic                      s1_detc_en_r;
  logic                      s1_inj_r;

  logic [DATA_WIDTH-1:0]     dec_data_s [2];
  logic [DATA_WIDTH-1:0]     dec_mask_s [2];
  logic                      dec_sbit_s [2];
  logic                      dec_dbit_s [2];

  logic [DATA_WIDTH+1:0]     cmp0_s;
  logic [DATA_WIDTH+1:0]     cmp1_s;
  logic                      fault_s;
  logic                      sbit_ev_s;
  logic                      dbit_ev_s;

  // Injection arm/consume FSM; inj_busy is registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_state_r <= INJ_IDLE;
      inj_busy    <= 1'b0;
    end else begin
      case (inj_state_r)
        INJ_IDLE: begin
          if (inj_req) begin
            inj_state_r <= INJ_ARMED;
            inj_busy    <= 1'b1;
          end else begin
            inj_busy    <= 1'b0;
          end
        end
        INJ_ARMED: begin
          if (valid_in && detc_en) begin
            inj_state_r <= INJ_IDLE;
            inj_busy    <= 1'b0;
          end else begin
            inj_busy    <= 1'b1;
          end
        end
        default: begin
          inj_state_r <= INJ_IDLE;
          inj_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture qualified read words; valid tracks valid_in every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_data_r    <= '0;
      s1_parity_r  <= '0;
      s1_bypass_r  <= 1'b0;
      s1_detc_en_r <= 1'b0;
      s1_inj_r     <= 1'b0;
    end else begin
      s1_valid_r <= valid_in;
      if (valid_in) begin
        s1_data_r    <= data_in;
        s1_parity_r  <= parity_in;
        s1_bypass_r  <= bypass;
        s1_detc_en_r <= detc_en;
        s1_inj_r     <= (inj_state_r == INJ_ARMED) && detc_en;
      end
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_copy
    ecc_secded_dec #(
      .DATA_WIDTH  (DATA_WIDTH),
      .PARITY_WIDTH(PARITY_WIDTH)
    ) u_dec (
      .data_in  (s1_data_r),
      .parity_in(s1_parity_r),
      .bypass   (s1_bypass_r),
      .data_out (dec_data_s[c]),
      .mask     (dec_mask_s[c]),
      .sbit_err (dec_sbit_s[c]),
      .dbit_err (dec_dbit_s[c])
    );
  end

  // Lockstep compare; an injected word flips bit 0 of the copy-1 correction mask
  always_comb begin
    cmp0_s    = {dec_sbit_s[0], dec_dbit_s[0], dec_mask_s[0]};
    cmp1_s    = {dec_sbit_s[1], dec_dbit_s[1],
                 dec_mask_s[1] ^ {{(DATA_WIDTH-1){1'b0}}, s1_inj_r}};
    fault_s   = s1_valid_r && s1_detc_en_r && (cmp0_s != cmp1_s);
    sbit_ev_s = s1_valid_r && dec_sbit_s[0];
    dbit_ev_s = s1_valid_r && dec_dbit_s[0];
  end

  // Stage 2: registered result; on a fault the raw word is forwarded untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sbit_err  <= 1'b0;
      dbit_err  <= 1'b0;
      ecc_fault <= 1'b0;
    end else begin
      valid_out <= s1_valid_r;
      if (s1_valid_r) begin
        data_out  <= fault_s ? s1_data_r : dec_data_s[0];
        sbit_err  <= dec_sbit_s[0];
        dbit_err  <= dec_dbit_s[0];
        ecc_fault <= fault_s;
      end else begin
        sbit_err  <= 1'b0;
        dbit_err  <= 1'b0;
        ecc_fault <= 1'b0;
      end
    end
  end

  // Saturating event counters; clear beats a coincident event
  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      fault_cnt <= '0;
    end else if (cnt_clr) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      fault_cnt <= '0;
    end else begin
      sbit_cnt  <= sat_inc(sbit_cnt, sbit_ev_s);
      dbit_cnt  <= sat_inc(dbit_cnt, dbit_ev_s);
      fault_cnt <= sat_inc(fault_cnt, fault_s);
    end
  end

  // Sticky fault flag; a coincident fault beats clear
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sticky <= 1'b0;
    end else if (fault_s) begin
      fault_sticky <= 1'b1;
    end else if (cnt_clr) begin
      fault_sticky <= 1'b0;
    end
  end

  assign irq = IRQ_EN && (fault_cnt >= THRESH);
endmodule

// File: tb/tb_ecc_lockstep_chk.sv
// Self-checking bench for ecc_lockstep_chk: vector table plus injection/clear/reset sequences,
// scoreboard queue with expected output cycle, counter model checked every cycle.

module tb_ecc_lockstep_chk;
  localparam int DW = 172;
  localparam int PW = 9;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic [PW-1:0] parity_in;
  logic          bypass;
  logic          detc_en;
  logic          inj_req;
  logic          cnt_clr;
  logic          valid_out, sbit_err, dbit_err, ecc_fault, inj_busy, fault_sticky, irq;
  logic [DW-1:0] data_out;
  logic [15:0]   sbit_cnt, dbit_cnt, fault_cnt;
  logic          b_valid_out, b_sbit_err, b_dbit_err, b_ecc_fault, b_inj_busy, b_fault_sticky, b_irq;
  logic [DW-1:0] b_data_out;
  logic [1:0]    b_sbit_cnt, b_dbit_cnt, b_fault_cnt;

  ecc_lockstep_chk dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .parity_in(parity_in),
    .bypass(bypass), .detc_en(detc_en), .inj_req(inj_req), .cnt_clr(cnt_clr),
    .valid_out(valid_out), .data_out(data_out), .sbit_err(sbit_err), .dbit_err(dbit_err),
    .ecc_fault(ecc_fault), .inj_busy(inj_busy), .fault_sticky(fault_sticky),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .irq(irq)
  );

  ecc_lockstep_chk #(.CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .parity_in(parity_in),
    .bypass(bypass), .detc_en(detc_en), .inj_req(inj_req), .cnt_clr(cnt_clr),
    .valid_out(b_valid_out), .data_out(b_data_out), .sbit_err(b_sbit_err), .dbit_err(b_dbit_err),
    .ecc_fault(b_ecc_fault), .inj_busy(b_inj_busy), .fault_sticky(b_fault_sticky),
    .sbit_cnt(b_sbit_cnt), .dbit_cnt(b_dbit_cnt), .fault_cnt(b_fault_cnt), .irq(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        sbit;
    logic        dbit;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    int   f0;
    int   f1;
    int   pf;
    logic byp;
    logic detc;
    logic esb;
    logic edb;
    logic ecorr;
  } vec_t;

  exp_t q[$];
  vec_t vecs [11];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   m_sbit  = 0;
  int   m_dbit  = 0;
  int   m_fault = 0;
  logic m_sticky = 1'b0;

  localparam logic [DW-1:0] P5A = {{21{8'h5A}}, 4'h5};
  localparam logic [DW-1:0] PA5 = {{21{8'hA5}}, 4'hA};
  localparam logic [DW-1:0] PC  = {43{4'hC}};

  // Hamming encoder built from an explicit codeword layout plus overall parity
  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    logic [255:0]  cw;
    logic [PW-1:0] par;
    int k;
    cw = '0;
    k  = 0;
    for (int p = 1; p < 256; p++) begin
      if (((p & (p - 1)) != 0) && (k < DW)) begin
        cw[p] = d[k];
        k++;
      end
    end
    par = '0;
    for (int j = 0; j < PW - 1; j++) begin
      for (int p = 1; p < 256; p++) begin
        if (((p >> j) & 1) == 1) par[j] = par[j] ^ cw[p];
      end
    end
    par[PW-1] = (^d) ^ (^par[PW-2:0]);
    return par;
  endfunction

  function automatic int satv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor(input logic rst_pre, input logic clr_pre);
    exp_t e;
    logic exp_valid;
    logic pop_fault;
    pop_fault = 1'b0;
    if (rst_pre) begin
      q.delete();
      m_sbit = 0; m_dbit = 0; m_fault = 0; m_sticky = 1'b0;
    end
    exp_valid = !rst_pre && (q.size() > 0) && (q[0].due <= cyc);
    check("valid_out", 192'(valid_out), 192'(exp_valid));
    check("w2_valid_out", 192'(b_valid_out), 192'(exp_valid));
    if (exp_valid) begin
      e = q.pop_front();
      pop_fault = e.fault;
      check("data_out", 192'(data_out), 192'(e.data));
      check("w2_data_out", 192'(b_data_out), 192'(e.data));
      check("sbit_err", 192'(sbit_err), 192'(e.sbit));
      check("dbit_err", 192'(dbit_err), 192'(e.dbit));
      check("ecc_fault", 192'(ecc_fault), 192'(e.fault));
      if (!clr_pre) begin
        if (e.sbit)  m_sbit++;
        if (e.dbit)  m_dbit++;
        if (e.fault) m_fault++;
      end
      if (e.fault) m_sticky = 1'b1;
    end else begin
      check("idle_flags", 192'({sbit_err, dbit_err, ecc_fault}), 192'(3'b000));
    end
    if (clr_pre && !rst_pre) begin
      m_sbit = 0; m_dbit = 0; m_fault = 0;
      if (!pop_fault) m_sticky = 1'b0;
    end
    check("sbit_cnt", 192'(sbit_cnt), 192'(satv(m_sbit, 65535)));
    check("dbit_cnt", 192'(dbit_cnt), 192'(satv(m_dbit, 65535)));
    check("fault_cnt", 192'(fault_cnt), 192'(satv(m_fault, 65535)));
    check("w2_sbit_cnt", 192'(b_sbit_cnt), 192'(satv(m_sbit, 3)));
    check("w2_dbit_cnt", 192'(b_dbit_cnt), 192'(satv(m_dbit, 3)));
    check("w2_fault_cnt", 192'(b_fault_cnt), 192'(satv(m_fault, 3)));
    check("fault_sticky", 192'(fault_sticky), 192'(m_sticky));
    check("irq", 192'(irq), 192'(m_fault >= 1));
    check("w2_irq", 192'(b_irq), 192'(m_fault >= 1));
  endtask

  task automatic step();
    logic rp, cp;
    rp = rst;
    cp = cnt_clr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor(rp, cp);
    rst      = 1'b0;
    valid_in = 1'b0;
    inj_req  = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic [DW-1:0] clean, input int f0, input int f1, input int pf,
                       input logic byp, input logic detc, input logic esb, input logic edb,
                       input logic ecorr, input logic eflt);
    logic [DW-1:0] raw;
    logic [PW-1:0] par;
    exp_t e;
    raw = clean;
    par = enc(clean);
    if (f0 >= 0) raw[f0] = ~raw[f0];
    if (f1 >= 0) raw[f1] = ~raw[f1];
    if (pf >= 0) par[pf] = ~par[pf];
    valid_in  = 1'b1;
    data_in   = raw;
    parity_in = par;
    bypass    = byp;
    detc_en   = detc;
    e.due   = cyc + 2;
    e.data  = (eflt || !ecorr) ? raw : clean;
    e.sbit  = esb;
    e.dbit  = edb;
    e.fault = eflt;
    q.push_back(e);
    step();
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; parity_in = '0;
    bypass = 1'b0; detc_en = 1'b1; inj_req = 1'b0; cnt_clr = 1'b0;

    vecs[0]  = '{P5A, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{P5A, 37, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{P5A,  3, 90, -1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{PA5, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{PA5, 171, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{PA5,  0, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{P5A, 37, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{PC,  -1, -1,  2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{PC,  -1, -1,  8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{PC,  10, 11, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{P5A,  3, -1,  4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    step();
    rst = 1'b1;
    step();
    check("reset_data_out", 192'(data_out), 192'(0));
    check("reset_inj_busy", 192'(inj_busy), 192'(0));

    foreach (vecs[i]) begin
      drive(vecs[i].data, vecs[i].f0, vecs[i].f1, vecs[i].pf, vecs[i].byp, vecs[i].detc,
            vecs[i].esb, vecs[i].edb, vecs[i].ecorr, 1'b0);
    end
    idle(3);

    // injection on a clean word, then on a single-error word, then in bypass
    inj_req = 1'b1;
    step();
    check("inj_busy_armed", 192'(inj_busy), 192'(1));
    drive(P5A, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("inj_busy_consumed", 192'(inj_busy), 192'(0));
    idle(2);
    check("irq_after_fault", 192'(irq), 192'(1));
    check("sticky_after_fault", 192'(fault_sticky), 192'(1));
    inj_req = 1'b1;
    step();
    drive(PA5, 37, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    inj_req = 1'b1;
    step();
    drive(PC, 5, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // detc_en=0 words do not consume an armed injection
    inj_req = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      drive(PA5, -1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("inj_busy_held", 192'(inj_busy), 192'(1));
    end
    drive(PA5, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("inj_busy_released", 192'(inj_busy), 192'(0));
    idle(2);

    // saturation of the 2-bit counters, then clear coincident with a fault
    cnt_clr = 1'b1;
    step();
    check("sticky_cleared", 192'(fault_sticky), 192'(0));
    for (int i = 0; i < 5; i++) drive(P5A, 37, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("sbit_cnt_5", 192'(sbit_cnt), 192'(16'd5));
    check("w2_sbit_cnt_sat", 192'(b_sbit_cnt), 192'(2'd3));
    inj_req = 1'b1;
    step();
    drive(P5A, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cnt_clr = 1'b1;
    step();
    check("clr_vs_fault_cnt", 192'(fault_cnt), 192'(0));
    check("clr_vs_fault_sticky", 192'(fault_sticky), 192'(1));
    check("clr_vs_fault_irq", 192'(irq), 192'(0));
    idle(2);

    // reset with words in flight and injection armed
    inj_req = 1'b1;
    step();
    drive(PA5, 37, -1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("inj_busy_pre_reset", 192'(inj_busy), 192'(1));
    rst = 1'b1;
    drive(PC, -1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_inj_busy", 192'(inj_busy), 192'(0));
    check("rst_data_out", 192'(data_out), 192'(0));
    check("rst_sticky", 192'(fault_sticky), 192'(0));
    idle(3);
    drive(P5A, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("scoreboard_drained", 192'(q.size()), 192'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
